// File: rtl/accelerator_pkg.sv
// Shared types for the scalar broadcast path: SEW encodings, FSM states and
// the beat-counter sizing helper.
package accelerator_pkg;

  typedef enum logic [1:0] {
    SEW_8    = 2'd0,
    SEW_16   = 2'd1,
    SEW_32   = 2'd2,
    SEW_RSVD = 2'd3
  } sew_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam int SCALAR_WIDTH = 32;

  // Width that holds ceil((2^vl_width - 1) / num_pe) without wrapping.
  function automatic int beats_width(input int vl_width, input int num_pe);
    int max_beats;
    max_beats = (((1 << vl_width) - 1) + num_pe - 1) / num_pe;
    return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/scalar_lane_extend.sv
// Combinational SEW-based zero/sign extension of a scalar operand to one PE lane.
// SEW_RSVD falls through to the 32-bit case.
module scalar_lane_extend
  import accelerator_pkg::*;
#(
  parameter int PE_WIDTH = 32
) (
  input  logic [SCALAR_WIDTH-1:0] scalar,
  input  logic [1:0]              vsew,
  input  logic                    sign_ext,
  output logic [PE_WIDTH-1:0]     lane
);

  logic                    fill;
  logic [SCALAR_WIDTH-1:0] elem;

  always_comb begin
    case (sew_e'(vsew))
      SEW_8: begin
        fill = sign_ext & scalar[7];
        elem = {{24{fill}}, scalar[7:0]};
      end
      SEW_16: begin
        fill = sign_ext & scalar[15];
        elem = {{16{fill}}, scalar[15:0]};
      end
      default: begin
        fill = sign_ext & scalar[31];
        elem = scalar;
      end
    endcase
    // Fill the whole lane first so PE_WIDTH == 32 needs no zero-width replicate.
    lane = {PE_WIDTH{fill}};
    lane[SCALAR_WIDTH-1:0] = elem;
  end

endmodule

// File: rtl/scalar_broadcast_seq.sv
// Handshaked scalar broadcaster: latches one extended scalar per transaction and
// emits it replicated over NUM_PE lanes as ceil(vl/NUM_PE) masked beats.
module scalar_broadcast_seq
  import accelerator_pkg::*;
#(
  parameter int NUM_PE   = 4,
  parameter int PE_WIDTH = 32,
  parameter int VL_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SCALAR_WIDTH-1:0]      scalar_in,
  input  logic [1:0]                   vsew,
  input  logic                         sign_ext,
  input  logic [VL_WIDTH-1:0]          vl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PE*PE_WIDTH-1:0]   out_data,
  output logic [NUM_PE-1:0]            out_mask,
  output logic                         out_last
);

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // waits on ready, and an offered beat holds stable until it is taken.

  localparam int CW = beats_width(VL_WIDTH, NUM_PE);
  localparam int AW = VL_WIDTH + CW + $clog2(NUM_PE) + 2;

  state_e                       state, state_d;
  logic [PE_WIDTH-1:0]          ext_lane, lane_q, src_lane;
  logic [VL_WIDTH-1:0]          vl_q, src_vl;
  logic [CW-1:0]                k_q, k_d, src_k;
  logic [AW-1:0]                base;
  logic                         accept, advance;
  logic [NUM_PE-1:0]            beat_mask, mask_d;
  logic [NUM_PE*PE_WIDTH-1:0]   beat_data, data_d;
  logic                         beat_last, last_d;

  scalar_lane_extend #(
    .PE_WIDTH (PE_WIDTH)
  ) u_extend (
    .scalar   (scalar_in),
    .vsew     (vsew),
    .sign_ext (sign_ext),
    .lane     (ext_lane)
  );

  assign out_valid = (state == ST_EMIT);
  assign advance   = out_valid && out_ready;
  assign in_ready  = (state == ST_IDLE) || (advance && out_last);
  assign accept    = in_valid && in_ready;

  // Next beat to register: beat 0 of a fresh accept, else beat k+1 of the
  // latched transaction. Only used on accept or a non-final advance.
  always_comb begin
    src_lane  = accept ? ext_lane : lane_q;
    src_vl    = accept ? vl : vl_q;
    src_k     = accept ? '0 : k_q + CW'(1);
    base      = AW'(src_k) * AW'(NUM_PE);
    beat_mask = '0;
    beat_data = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      beat_mask[i] = (base + AW'(i)) < AW'(src_vl);
      beat_data[i*PE_WIDTH +: PE_WIDTH] = beat_mask[i] ? src_lane : '0;
    end
    beat_last = (base + AW'(NUM_PE)) >= AW'(src_vl);
  end

  always_comb begin
    state_d = state;
    k_d     = k_q;
    data_d  = out_data;
    mask_d  = out_mask;
    last_d  = out_last;
    case (state)
      ST_IDLE: begin
        if (accept && (vl != '0)) begin
          state_d = ST_EMIT;
          k_d     = '0;
          data_d  = beat_data;
          mask_d  = beat_mask;
          last_d  = beat_last;
        end
      end
      ST_EMIT: begin
        if (accept && (vl != '0)) begin
          k_d    = '0;
          data_d = beat_data;
          mask_d = beat_mask;
          last_d = beat_last;
        end else if (advance && out_last) begin
          // Covers both a plain finish and a same-cycle accept with vl == 0.
          state_d = ST_IDLE;
          k_d     = '0;
          data_d  = '0;
          mask_d  = '0;
          last_d  = 1'b0;
        end else if (advance) begin
          k_d    = src_k;
          data_d = beat_data;
          mask_d = beat_mask;
          last_d = beat_last;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      lane_q   <= '0;
      vl_q     <= '0;
      k_q      <= '0;
      out_data <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        lane_q <= ext_lane;
        vl_q   <= vl;
      end
      k_q      <= k_d;
      out_data <= data_d;
      out_mask <= mask_d;
      out_last <= last_d;
    end
  end

endmodule

// File: tb/tb_scalar_broadcast_seq.sv
// Directed bench for scalar_broadcast_seq: a 32-bit-lane and a 64-bit-lane
// instance share stimulus; every expected beat is hand-derived.
module tb_scalar_broadcast_seq;

  logic         clk;
  logic         n_reset;
  logic         in_valid;
  logic [31:0]  scalar_in;
  logic [1:0]   vsew;
  logic         sign_ext;
  logic [7:0]   vl;
  logic         out_ready;

  logic         in_ready, out_valid, out_last;
  logic [127:0] out_data;
  logic [3:0]   out_mask;

  logic         in_ready_w, out_valid_w, out_last_w;
  logic [255:0] out_data_w;
  logic [3:0]   out_mask_w;

  int checks = 0;
  int errors = 0;

  scalar_broadcast_seq u_dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scalar_in (scalar_in),
    .vsew      (vsew),
    .sign_ext  (sign_ext),
    .vl        (vl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last)
  );

  scalar_broadcast_seq #(.NUM_PE(4), .PE_WIDTH(64), .VL_WIDTH(8)) u_dut_w (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .scalar_in (scalar_in),
    .vsew      (vsew),
    .sign_ext  (sign_ext),
    .vl        (vl),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_data  (out_data_w),
    .out_mask  (out_mask_w),
    .out_last  (out_last_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rep32(input logic [31:0] v, input logic [3:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] rep64(input logic [63:0] v, input logic [3:0] m);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*64 +: 64] = v;
    return r;
  endfunction

  // Driver: offer a transaction; it is sampled on the next rising edge.
  task automatic drive_txn(input logic [31:0] s, input logic [1:0] sew,
                           input logic se, input logic [7:0] len);
    in_valid  = 1'b1;
    scalar_in = s;
    vsew      = sew;
    sign_ext  = se;
    vl        = len;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_mask, out_data} !== {1'b1, 1'b0, 1'b0, 4'h0, 128'h0}) begin
      errors++;
      $display("FAIL reset_32 got rdy=%b vld=%b last=%b mask=%h data=%h, want 1 0 0 0 0",
               in_ready, out_valid, out_last, out_mask, out_data);
    end
    checks++;
    if ({in_ready_w, out_valid_w, out_last_w, out_mask_w, out_data_w} !== {1'b1, 1'b0, 1'b0, 4'h0, 256'h0}) begin
      errors++;
      $display("FAIL reset_64 got rdy=%b vld=%b data=%h, want 1 0 0", in_ready_w, out_valid_w, out_data_w);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
  endtask

  task automatic test_sew8_single;
    @(posedge clk); #1;
    drive_txn(32'h000000A5, 2'd0, 1'b0, 8'd4);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL sew8_ready_idle got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_mask, out_data} !== {1'b1, 1'b1, 4'hF, rep32(32'hA5, 4'hF)}) begin
      errors++;
      $display("FAIL sew8_beat0 got v=%b l=%b m=%h d=%h", out_valid, out_last, out_mask, out_data);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL sew8_after got vld,rdy=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_sew16_sign;
    @(posedge clk); #1;
    drive_txn(32'h1234F00D, 2'd1, 1'b1, 8'd6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_mask, out_data} !==
        {1'b0, 1'b1, 1'b0, 4'hF, rep32(32'hFFFFF00D, 4'hF)}) begin
      errors++;
      $display("FAIL sew16_beat0 got r=%b v=%b l=%b m=%h d=%h", in_ready, out_valid, out_last, out_mask, out_data);
    end
    checks++;
    if (out_data_w !== rep64(64'hFFFFFFFFFFFFF00D, 4'hF)) begin
      errors++; $display("FAIL sew16_beat0_64 got %h", out_data_w);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_mask, out_data} !==
        {1'b1, 1'b1, 4'h3, 64'h0, 32'hFFFFF00D, 32'hFFFFF00D}) begin
      errors++;
      $display("FAIL sew16_beat1 got v=%b l=%b m=%h d=%h", out_valid, out_last, out_mask, out_data);
    end
    checks++;
    if ({out_mask_w, out_data_w} !== {4'h3, rep64(64'hFFFFFFFFFFFFF00D, 4'h3)}) begin
      errors++; $display("FAIL sew16_beat1_64 got m=%h d=%h", out_mask_w, out_data_w);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sew16_done got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall;
    logic [4:0] rdy_seq;
    logic [3:0] masks [3];
    logic [2:0] lasts;
    int b;
    int hs;
    rdy_seq  = 5'b11001;   // cycle c uses rdy_seq[c]: 1,0,0,1,1
    masks[0] = 4'hF;
    masks[1] = 4'hF;
    masks[2] = 4'h1;
    lasts    = 3'b100;
    b  = 0;
    hs = 0;
    @(posedge clk); #1;
    drive_txn(32'h80000001, 2'd2, 1'b1, 8'd9);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = rdy_seq[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_mask, out_data} !==
          {1'b1, lasts[b], masks[b], rep32(32'h80000001, masks[b])}) begin
        errors++;
        $display("FAIL stall_c%0d_beat%0d got v=%b l=%b m=%h d=%h", c, b, out_valid, out_last, out_mask, out_data);
      end
      checks++;
      if ({out_mask_w, out_data_w} !== {masks[b], rep64(64'hFFFFFFFF80000001, masks[b])}) begin
        errors++; $display("FAIL stall_c%0d_64 got m=%h d=%h", c, out_mask_w, out_data_w);
      end
      if (out_valid && out_ready) hs++;
      @(posedge clk);
      if (rdy_seq[c]) b++;
      #1;
      out_ready = (c < 4) ? rdy_seq[c+1] : 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({hs, out_valid} !== {32'd3, 1'b0}) begin
      errors++; $display("FAIL stall_count got beats=%0d vld=%b want 3 0", hs, out_valid);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] second_vl);
    @(posedge clk); #1;
    drive_txn(32'h00000055, 2'd0, 1'b0, 8'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_mask} !== {1'b0, 1'b1, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL b2b_beat0 got r=%b v=%b l=%b m=%h", in_ready, out_valid, out_last, out_mask);
    end
    @(posedge clk); #1;
    drive_txn(32'h0000007F, 2'd0, 1'b0, second_vl);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_mask, out_data} !==
        {1'b1, 1'b1, 1'b1, 4'h1, rep32(32'h55, 4'h1)}) begin
      errors++;
      $display("FAIL b2b_last got r=%b v=%b l=%b m=%h d=%h", in_ready, out_valid, out_last, out_mask, out_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (second_vl != 8'd0) begin
      if ({out_valid, out_last, out_mask, out_data} !== {1'b1, 1'b1, 4'h1, rep32(32'h7F, 4'h1)}) begin
        errors++;
        $display("FAIL b2b_second got v=%b l=%b m=%h d=%h", out_valid, out_last, out_mask, out_data);
      end
    end else begin
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL b2b_vl0 got vld,rdy=%b want 01", {out_valid, in_ready});
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_done got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_vl_zero;
    @(posedge clk); #1;
    drive_txn(32'hFFFFFFFF, 2'd2, 1'b1, 8'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_mask} !== {1'b0, 1'b1, 4'h0}) begin
        errors++;
        $display("FAIL vl0_c%0d got vld=%b rdy=%b mask=%h", c, out_valid, in_ready, out_mask);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_rsvd_sew;
    @(posedge clk); #1;
    drive_txn(32'hDEADBEEF, 2'd3, 1'b1, 8'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_mask, out_data} !== {1'b1, 1'b1, 4'h3, rep32(32'hDEADBEEF, 4'h3)}) begin
      errors++;
      $display("FAIL rsvd_beat got v=%b l=%b m=%h d=%h", out_valid, out_last, out_mask, out_data);
    end
    checks++;
    if (out_data_w !== rep64(64'hFFFFFFFFDEADBEEF, 4'h3)) begin
      errors++; $display("FAIL rsvd_beat_64 got %h", out_data_w);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    drive_txn(32'h000000A5, 2'd0, 1'b1, 8'd12);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_mask, out_data, out_data_w} !==
        {4'hF, rep32(32'hFFFFFFA5, 4'hF), rep64(64'hFFFFFFFFFFFFFFA5, 4'hF)}) begin
      errors++; $display("FAIL rstmid_beat0 got m=%h d=%h d64=%h", out_mask, out_data, out_data_w);
    end
    @(posedge clk); #1;
    n_reset   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last} !== 2'b10) begin
      errors++; $display("FAIL rstmid_beat1 got vld,last=%b want 10", {out_valid, out_last});
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_mask, out_data, out_valid_w, out_data_w} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 128'h0, 1'b0, 256'h0}) begin
      errors++;
      $display("FAIL rstmid_values got r=%b v=%b l=%b m=%h d=%h", in_ready, out_valid, out_last, out_mask, out_data);
    end
    @(posedge clk); #1;
    drive_txn(32'h00008000, 2'd1, 1'b1, 8'd3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_mask, out_data} !== {1'b1, 1'b1, 4'h7, rep32(32'hFFFF8000, 4'h7)}) begin
      errors++;
      $display("FAIL rstmid_fresh got v=%b l=%b m=%h d=%h", out_valid, out_last, out_mask, out_data);
    end
    checks++;
    if (out_data_w !== rep64(64'hFFFFFFFFFFFF8000, 4'h7)) begin
      errors++; $display("FAIL rstmid_fresh_64 got %h", out_data_w);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_done got vld=%b want 0", out_valid);
    end
  endtask

  initial begin
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    scalar_in = '0;
    vsew      = '0;
    sign_ext  = 1'b0;
    vl        = '0;
    out_ready = 1'b0;
    test_reset();
    test_sew8_single();
    test_sew16_sign();
    test_stall();
    test_back_to_back(8'd1);
    test_back_to_back(8'd0);
    test_vl_zero();
    test_rsvd_sew();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_broadcast_seq.md
# scalar_broadcast_seq

Sequenced, handshaked scalar broadcaster. It takes one scalar operand per transaction and extends it to a PE lane using the element width (SEW), with zero or sign fill. It then replicates the lane across `NUM_PE` lanes and emits it as ceil(vl/NUM_PE) beats, each with a per-lane active mask. It sits between the scalar operand path and the PE array input mux, and replaces the single-shot combinational replicate stage.

## Interface
Parameters:
- `NUM_PE`, 4: lanes per beat; must be ≥1.
- `PE_WIDTH`, 32: bits per lane; must be ≥32.
- `VL_WIDTH`, 8: width of the vector-length field.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: transaction offered.
- `in_ready` out 1: transaction accepted when `in_valid && in_ready`.
- `scalar_in` in 32: scalar operand.
- `vsew` in 2: element width; 0=8b, 1=16b, 2=32b, 3=reserved.
- `sign_ext` in 1: 1 = sign-fill the lane, 0 = zero-fill the lane.
- `vl` in VL_WIDTH: number of active elements.
- `out_valid` out 1: beat present.
- `out_ready` in 1: consumer accepts the beat when `out_valid && out_ready`.
- `out_data` out NUM_PE*PE_WIDTH: replicated beat; lane i occupies bits [i*PE_WIDTH +: PE_WIDTH].
- `out_mask` out NUM_PE: lane i is active.
- `out_last` out 1: final beat of the transaction.

## Operation
- **Lane value.** Take the low SEW bits of `scalar_in` and extend them to PE_WIDTH bits. The fill is zero, or the MSB of the element when `sign_ext`=1. `vsew`=3 is handled as 32b.
- **Latching.** The extended lane value, `vl` and the beat counter are latched on accept. After accept, the inputs are don't-care.
- **Beat k.** Lane i is active iff k*NUM_PE+i < vl. Active lanes carry the lane value; inactive lanes carry zero. `out_last` = 1 iff (k+1)*NUM_PE ≥ vl.
- **States.**
  - IDLE: `in_ready`=1, `out_valid`=0. On accept with vl≠0, go to EMIT with k=0. On accept with vl=0, stay in IDLE; the transaction is consumed and no beat is emitted.
  - EMIT: `out_valid`=1. On an out handshake with `out_last`=0, set k←k+1. On an out handshake with `out_last`=1, go to IDLE, unless a new accept happens in the same cycle.
- **Back-to-back.** `in_ready` = IDLE || (`out_valid && out_ready && out_last`). A same-cycle accept reloads the registers. The next cycle shows beat 0 of the new transaction. If the new vl=0, go to IDLE instead.
- **Stall.** While `out_valid && !out_ready`, `out_data`, `out_mask` and `out_last` hold stable.
- **Counter.** The beat counter is sized for ceil((2^VL_WIDTH−1)/NUM_PE) and never wraps.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_mask`=0, `out_last`=0, counter 0.
- Reset asserted mid-transaction aborts it. The next cycle after `n_reset` is sampled low shows the reset values. No partial beat follows.
- Latency: accept in cycle t → beat 0 valid in cycle t+1. All outputs come from registers.
- Throughput: one beat per cycle when `out_ready`=1. With back-to-back accepts, transactions incur no idle cycle between them.
- No combinational path from `out_ready` to `out_data`. `in_ready` depends combinationally on `out_ready`, by design.

## Structure
- `accelerator_pkg` holds the SEW encodings (`SEW_8`, `SEW_16`, `SEW_32`) as a 2-bit enum, and a helper constant for the beats-count width.
- Sub-module `scalar_lane_extend`: a combinational function of (scalar, vsew, sign_ext) → PE_WIDTH lane.
- The top level holds the FSM, counter and output registers, and generates the per-lane mask and zeroing.

## Test plan
Defaults NUM_PE=4, PE_WIDTH=32 unless stated.
- vsew=0, sign_ext=0, scalar=0x000000A5, vl=4, `out_ready`=1 → one beat: every lane 0x000000A5, mask 4'b1111, `out_last`=1 in cycle t+1; `in_ready`=1 at t+2.
- vsew=1, sign_ext=1, scalar=0x1234F00D, vl=6 → beat 0: lanes 0xFFFFF00D, mask 1111. Beat 1: lanes 0 and 1 = 0xFFFFF00D, lanes 2 and 3 = 0, mask 0011, `out_last`=1.
- vsew=2, vl=9, `out_ready` toggled 1,0,0,1,1 → three beats with masks 1111, 1111, 0001. Outputs hold during stalls; no beat is dropped or duplicated.
- Back-to-back: hold `in_valid` with a second transaction (0x7F, vsew=0, vl=1) during the last beat of the first → beat 0 of the second in the next cycle with mask 0001, and no idle cycle between the transactions.
- vl=0 → accepted in one cycle; `out_valid` stays 0; `in_ready` stays 1.
- `n_reset` pulled low while in EMIT mid-beat → next cycle shows the reset values. A fresh transaction afterwards behaves normally. Also run with PE_WIDTH=64 to check sign extension across 64 bits.
